// File: rtl/bidir_bus_port.sv
// Half-duplex W-bit tristate bus port. It registers both drive and capture, and it inserts
// a TA-cycle floating turnaround on each direction change, so neither side drives over the other.
module bidir_bus_port #(
   parameter int unsigned W  = 8,
   parameter int unsigned TA = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         tx_valid,
   input  logic [W-1:0] tx_data,
   output logic         tx_ready,
   inout  wire  [W-1:0] Dio,
   output logic [W-1:0] rx_data,
   output logic         rx_valid,
   output logic         dir,
   output logic         busy
);

   typedef enum logic [1:0] {
      StRx,
      StTurnTx,
      StDrive,
      StTurnRx
   } state_e;

   localparam bit         TaZero = (TA == 0);
   localparam logic [3:0] TaLoad = TaZero ? 4'd0 : 4'(TA - 1);

   state_e       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         oe_q, oe_d;
   logic [W-1:0] dout_q, dout_d;
   logic [W-1:0] rx_data_q, rx_data_d;
   logic         rx_valid_q, rx_valid_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StRx;
         cnt_q      <= 4'd0;
         oe_q       <= 1'b0;
         dout_q     <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         oe_q       <= oe_d;
         dout_q     <= dout_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StRx: begin
            if (tx_valid) begin
               if (TaZero) begin
                  state_d = StDrive;
               end else begin
                  state_d = StTurnTx;
                  cnt_d   = TaLoad;
               end
            end
         end
         // tx_valid is deliberately ignored here: a dropped request still completes the gap
         StTurnTx: begin
            if (cnt_q == 4'd0) begin
               state_d = StDrive;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDrive: begin
            if (!tx_valid) begin
               if (TaZero) begin
                  state_d = StRx;
               end else begin
                  state_d = StTurnRx;
                  cnt_d   = TaLoad;
               end
            end
         end
         StTurnRx: begin
            if (cnt_q == 4'd0) begin
               state_d = StRx;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = StRx;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_comb begin
      oe_d       = 1'b0;
      dout_d     = dout_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      unique case (state_q)
         StRx: begin
            rx_data_d  = Dio;
            rx_valid_d = 1'b1;
         end
         StDrive: begin
            if (tx_valid) begin
               oe_d   = 1'b1;
               dout_d = tx_data;
            end
         end
         default: begin
         end
      endcase

      tx_ready = (state_q == StDrive);
      busy     = (state_q != StRx);
      dir      = oe_q;
      rx_data  = rx_data_q;
      rx_valid = rx_valid_q;
   end

   assign Dio = oe_q ? dout_q : {W{1'bz}};

endmodule

// File: tb/tb_bidir_bus_port.sv
// Randomised scoreboard bench for bidir_bus_port, with one instance for each of TA = 0, 1 and 15.
// The expected edge of every capture and driven word comes from the request/turnaround timing rules.
module tb_bidir_bus_port;

   localparam int unsigned W  = 8;
   localparam int          NI = 3;

   function automatic int unsigned ta_of(int k);
      case (k)
         0:       return 0;
         1:       return 1;
         default: return 15;
      endcase
   endfunction

   typedef struct packed {
      int unsigned  at;
      logic [W-1:0] data;
   } ev_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         tx_valid;
   logic [W-1:0] tx_data;
   logic         peer_oe;
   logic [W-1:0] peer_data;
   logic [1:0]   sel;

   logic [NI-1:0] ready_v, valid_v, dir_v, busy_v;
   logic [W-1:0]  rxd_v [NI];
   logic [W-1:0]  bus_v [NI];

   always #5 clk = ~clk;

   for (genvar k = 0; k < NI; k++) begin : g_dut
      wire [W-1:0] bus;
      assign bus      = (peer_oe && sel == 2'(k)) ? peer_data : {W{1'bz}};
      assign bus_v[k] = bus;
      bidir_bus_port #(
         .W (W),
         .TA(ta_of(k))
      ) u_dut (
         .clk     (clk),
         .rst_n   (rst_n),
         .tx_valid(tx_valid && sel == 2'(k)),
         .tx_data (tx_data),
         .tx_ready(ready_v[k]),
         .Dio     (bus),
         .rx_data (rxd_v[k]),
         .rx_valid(valid_v[k]),
         .dir     (dir_v[k]),
         .busy    (busy_v[k])
      );
   end

   logic         m_ready, m_valid, m_dir, m_busy;
   logic [W-1:0] m_rxd, m_bus;
   always_comb begin
      m_ready = ready_v[sel];
      m_valid = valid_v[sel];
      m_dir   = dir_v[sel];
      m_busy  = busy_v[sel];
      m_rxd   = rxd_v[sel];
      m_bus   = bus_v[sel];
   end

   // Model state: edge counter, expected event queues and the DRIVE / non-RX windows.
   int unsigned  ecnt = 0;
   ev_t          capq[$];
   ev_t          txq[$];
   int unsigned  ready_lo = 0, ready_hi = 0, busy_lo = 0, busy_hi = 0;
   logic [W-1:0] exp_last = '0;
   bit           mon_en = 1'b0;
   int           checks = 0;
   int           errors = 0;

   always @(posedge clk) ecnt <= ecnt + 1;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (sel %0d, edge %0d): got %0h expected %0h", name, sel, ecnt, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      ev_t e;
      if (mon_en) begin
         check("tx_ready", 64'(m_ready), 64'(ecnt >= ready_lo && ecnt < ready_hi));
         check("busy", 64'(m_busy), 64'(ecnt >= busy_lo && ecnt < busy_hi));
         if (m_valid) begin
            if (capq.size() == 0) begin
               check("rx_valid spurious", 64'(m_valid), 64'(0));
            end else begin
               e = capq.pop_front();
               check("rx capture edge", 64'(ecnt), 64'(e.at));
               check("rx_data", 64'(m_rxd), 64'(e.data));
               exp_last = e.data;
            end
         end else begin
            if (capq.size() != 0 && capq[0].at == ecnt) begin
               check("rx_valid missing", 64'(m_valid), 64'(1));
               void'(capq.pop_front());
            end
            check("rx_data hold", 64'(m_rxd), 64'(exp_last));
         end
         if (m_dir) begin
            if (txq.size() == 0) begin
               check("dir spurious", 64'(m_dir), 64'(0));
            end else begin
               e = txq.pop_front();
               check("drive edge", 64'(ecnt), 64'(e.at));
               check("Dio word", 64'(m_bus), 64'(e.data));
            end
         end else if (txq.size() != 0 && txq[0].at == ecnt) begin
            check("dir missing", 64'(m_dir), 64'(1));
            void'(txq.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic peer_drive(logic [W-1:0] d);
      peer_oe   = 1'b1;
      peer_data = d;
      capq.push_back('{at: ecnt + 1, data: d});
   endtask

   task automatic rx_word(logic [W-1:0] d);
      tx_valid = 1'b0;
      peer_drive(d);
      tick();
   endtask

   task automatic rx_phase(int unsigned n);
      for (int i = 0; i < int'(n); i++) rx_word(W'($urandom));
   endtask

   task automatic do_reset(int unsigned cycles);
      rst_n     = 1'b0;
      tx_valid  = 1'b1;
      peer_oe   = 1'b1;
      peer_data = 8'hA5;
      ready_lo  = 0;
      ready_hi  = 0;
      busy_lo   = 0;
      busy_hi   = 0;
      capq.delete();
      txq.delete();
      for (int i = 0; i < int'(cycles); i++) begin
         tick();
         exp_last = '0;
         check("reset dir", 64'(m_dir), 64'(0));
         check("reset tx_ready", 64'(m_ready), 64'(0));
         check("reset rx_valid", 64'(m_valid), 64'(0));
         check("reset rx_data", 64'(m_rxd), 64'(0));
         check("reset busy", 64'(m_busy), 64'(0));
         check("reset Dio peer", 64'(m_bus), 64'(8'hA5));
      end
      rst_n    = 1'b1;
      tx_valid = 1'b0;
   endtask

   // A request seen at E0: DRIVE from E0+TA, accepts at E0+TA+1.., exit at X, RX again at X+TA.
   task automatic burst(int unsigned n, bit directed);
      int unsigned ta, e0, x;
      ta       = ta_of(int'(sel));
      e0       = ecnt + 1;
      x        = e0 + ta + n + 1;
      ready_lo = e0 + ta;
      ready_hi = x;
      busy_lo  = e0;
      busy_hi  = x + ta;
      tx_valid = 1'b1;
      tx_data  = W'($urandom);
      peer_drive(W'($urandom));
      tick();
      peer_oe = 1'b0;
      for (int i = 0; i < int'(ta); i++) begin
         tx_valid = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         tx_data  = W'($urandom);
         tick();
      end
      for (int i = 1; i <= int'(n); i++) begin
         tx_valid = 1'b1;
         tx_data  = directed ? W'(i * 17) : W'($urandom);
         txq.push_back('{at: ecnt + 1, data: tx_data});
         tick();
      end
      tx_valid = 1'b0;
      tx_data  = W'($urandom);
      tick();
      for (int i = 0; i < int'(ta); i++) tick();
   endtask

   task automatic burst_reset();
      int unsigned ta, e0, r;
      ta       = ta_of(int'(sel));
      e0       = ecnt + 1;
      r        = e0 + ta + 3;
      ready_lo = e0 + ta;
      ready_hi = r;
      busy_lo  = e0;
      busy_hi  = r;
      tx_valid = 1'b1;
      tx_data  = W'($urandom);
      peer_drive(W'($urandom));
      tick();
      peer_oe = 1'b0;
      for (int i = 0; i < int'(ta); i++) tick();
      for (int i = 0; i < 2; i++) begin
         tx_data = W'($urandom);
         txq.push_back('{at: ecnt + 1, data: tx_data});
         tick();
      end
      rst_n   = 1'b0;
      tx_data = W'($urandom);
      tick();
      exp_last = '0;
      check("mid-burst reset dir", 64'(m_dir), 64'(0));
      check("mid-burst reset busy", 64'(m_busy), 64'(0));
      check("mid-burst reset rx_valid", 64'(m_valid), 64'(0));
      rst_n    = 1'b1;
      tx_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      tx_valid  = 1'b0;
      tx_data   = '0;
      peer_oe   = 1'b0;
      peer_data = '0;
      sel       = 2'd0;
      for (int k = 0; k < NI; k++) begin
         mon_en = 1'b0;
         sel    = 2'(k);
         do_reset(3);
         mon_en = 1'b1;
         rx_word(8'h3C);
         rx_word(8'hC3);
         rx_word(8'h5A);
         burst(3, 1'b1);
         rx_phase(2);
         repeat (12) begin
            burst($urandom_range(0, 5), 1'b0);
            rx_phase($urandom_range(1, 4));
         end
         burst_reset();
         rx_phase(3);
         burst(0, 1'b0);
         rx_phase(3);
         @(negedge clk);
         #1;
         check("capture queue drained", 64'(capq.size()), 64'(0));
         check("drive queue drained", 64'(txq.size()), 64'(0));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bidir_bus_port.md
# bidir_bus_port

Parametrised half-duplex bidirectional bus port: one W-bit tristate `Dio` bus shared with a peer, with registered drive, registered capture and an enforced turnaround gap between receive and transmit. It is the sequenced successor of our single-bit tristate port and sits between core logic (valid/ready transmit stream, receive strobe) and a shared pin bus. It guarantees that our side never drives the bus in the same cycle the peer could still be driving.

## Interface
Parameters
- `W`, 8: bus and data width, 1..64.
- `TA`, 1: turnaround cycles with the bus floating, inserted on each direction change, 0..15.

Ports
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tx_valid`  in  1  core has a word to transmit.
- `tx_data`  in  W  word to transmit; sampled on acceptance.
- `tx_ready`  out  1  port accepts `tx_data` this cycle (`tx_valid && tx_ready` = accept).
- `Dio`  inout  W  shared bus; driven with `dout_q` when `oe_q`=1, else `{W{1'bz}}`.
- `rx_data`  out  W  last word captured from `Dio`.
- `rx_valid`  out  1  `rx_data` updated at the preceding edge.
- `dir`  out  1  = `oe_q`; 1 while our side drives `Dio`.
- `busy`  out  1  1 in any state other than RX.

## Operation
- States: RX, TURN_TX, DRIVE, TURN_RX. The turnaround counter is 4 bits.
- RX:
  - `oe_q`=0.
  - Every edge: `rx_data`<=`Dio` and `rx_valid`<=1.
  - If `tx_valid`=1 at an edge: go to TURN_TX with the counter loaded with TA-1. If TA=0, go straight to DRIVE.
- TURN_TX:
  - `oe_q`=0, no capture, `rx_valid`<=0.
  - Counter decrements each edge. When the counter is 0, go to DRIVE.
  - `tx_valid` is ignored here; dropping it does not abort the turnaround.
- DRIVE:
  - `tx_ready`=1 (combinational, equal to state==DRIVE).
  - On an edge with `tx_valid`=1: `dout_q`<=`tx_data` and `oe_q`<=1. Each accepted word appears on `Dio` for exactly one cycle, starting after the accept edge.
  - Continuous `tx_valid` gives back-to-back words with no gaps.
  - On an edge with `tx_valid`=0: `oe_q`<=0, then go to TURN_RX with the counter loaded with TA-1. If TA=0, go to RX.
- TURN_RX:
  - `oe_q`=0, no capture, `rx_valid`<=0.
  - Counter decrements. When it is 0, go to RX.
- `rx_valid` is 0 on any edge not taken in RX.
- `rx_data` holds its value outside RX.

## Timing
- Reset (edge with `rst_n`=0) forces: state RX, `oe_q`=0, `dout_q`=0, `rx_data`=0, `rx_valid`=0, counter=0. After reset, `tx_ready`=0, `dir`=0, `busy`=0.
- Reset mid-DRIVE: `Dio` is released after that edge. No turnaround is inserted and the in-flight word is dropped.
- Request to first driven word, with `tx_valid` first seen high at edge E0 in RX:
  - TURN_TX occupies E0..E0+TA.
  - DRIVE is entered at E0+TA.
  - First accept is at E0+TA+1, and `Dio` is driven from E0+TA+1.
  - The bus floats for TA+1 cycles. With TA=0, the first accept is at E0+1.
- Last driven word to capture:
  - Last accept is at edge A.
  - `Dio` is driven during A..A+1, and `oe_q` falls at A+1.
  - TURN_RX covers TA cycles.
  - The first RX capture is at A+1+TA+1 = A+TA+2 (A+2 when TA=0).
- The edge at which RX sees `tx_valid` also captures `Dio` (`rx_valid`=1 after it). That is the last capture before transmitting.
- `tx_data` may change every cycle; only the value at accept edges matters.
- `tx_ready` never depends combinationally on `tx_valid`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles while `tx_valid`=1 and the peer drives 8'hA5 -> `Dio` is undriven by us, `tx_ready`=0, `rx_data`=0, `rx_valid`=0, `dir`=0, `busy`=0.
- Receive: W=8, peer drives 8'h3C, 8'hC3, 8'h5A on consecutive cycles -> `rx_data` follows with 1 edge of latency and `rx_valid`=1 for each.
- Burst transmit: W=8, TA=1, `tx_valid` high at E0 with words 8'h11, 8'h22, 8'h33 -> `Dio` floats for 2 cycles, then carries 11, 22, 33 back-to-back. `dir`=1 for exactly 3 cycles, `tx_ready` is first high at E0+1, and the first capture is 3 edges after the last accept.
- TA sweep: repeat the burst test with TA=0 and TA=15 -> the float gap is 1 and 16 cycles respectively. The counter wraps correctly, and no cycle has `dir`=1 within TA+1 cycles of RX.
- Reset mid-burst: assert `rst_n`=0 during the second word -> `dir`=0 after that edge, state RX, no TURN_RX gap, and capture resumes on the next edge.
- Single word / drop during turnaround: `tx_valid` pulses for 1 cycle in RX -> TURN_TX completes anyway, DRIVE sees `tx_valid`=0, no word is driven (`dir` stays 0), and the port returns to RX after TURN_RX.
